pulse_swallow_ctrl: RTL and testbench
=====================================

PULSE_SWALLOW_CTRL -- requirements
Module: pulse_swallow_ctrl

Interface
REQ-001 Parameter: WIDTH, 6, bit width of program (P) and swallow (S) values.
REQ-002 Parameter: P_DEF, 8, program value active after reset.
REQ-003 Parameter: S_DEF, 0, swallow value active after reset.
REQ-004 Port: clk_in  input  1  the single clock, which is the divide-by-3/4 prescaler output; all flops sample its rising edge.
REQ-005 Port: rstb  input  1  asynchronous, active-low reset.
REQ-006 Port: p_val  input  WIDTH  requested program count P.
REQ-007 Port: s_val  input  WIDTH  requested swallow count S.
REQ-008 Port: load  input  1  one-cycle strobe; captures p_val/s_val into the shadow register.
REQ-009 Port: mod  output  1  prescaler modulus select: 1 = divide-by-4, 0 = divide-by-3.
REQ-010 Port: tc  output  1  terminal-count pulse, high for the last clk_in cycle of each period.
REQ-011 Port: cfg_err  output  1  high while the active configuration was clamped (see REQ-019/020).

Function
REQ-012 A period SHALL be exactly P_act clk_in cycles, indexed c = 0..P_act-1, so that the overall division is 4*S_act + 3*(P_act-S_act) = 3*P_act + S_act input clocks.
REQ-013 FSM states: SWALLOW (mod=1) and MAIN (mod=0).
REQ-014 Period start: enter SWALLOW if S_act>0; otherwise enter MAIN.
REQ-015 SWALLOW -> MAIN after S_act cycles, unless S_act = P_act, in which case the period ends in SWALLOW.
REQ-016 MAIN -> period start after the cycle with c = P_act-1.
REQ-017 mod and tc SHALL be flop outputs with no combinational path from any input; mod = 1 exactly for c < S_act.
REQ-018 tc SHALL be 1 exactly for c = P_act-1; when P_act = 1, tc is 1 every cycle.
REQ-019 P = 0 SHALL be treated as P = 1 and set cfg_err.
REQ-020 S > P (after REQ-019) SHALL be clamped to S = P and set cfg_err.
REQ-021 load captures p_val/s_val into the shadow on its edge; the shadow is copied to P_act/S_act only at the period boundary (the edge ending the tc cycle).
REQ-022 If load coincides with the tc cycle, the newly loaded values SHALL govern the immediately following period.
REQ-023 Multiple loads within one period: only the last one takes effect.
REQ-024 A mid-period load SHALL NOT alter the current period's mod or tc timing.
REQ-025 cfg_err SHALL update together with P_act/S_act and hold for the whole period.

Reset
REQ-026 rstb low SHALL asynchronously force: shadow = active = (P_DEF, S_DEF) clamped per REQ-019/020; c = 0; tc = 0; cfg_err per the clamp; and the state and mod to the c = 0 value (SWALLOW with mod = 1 if S_DEF > 0, otherwise MAIN with mod = 0).
REQ-027 The first rising edge after rstb deasserts SHALL advance to c = 1 of the first period.
REQ-028 Reset asserted mid-period SHALL abandon that period; no tc is emitted for it.

Structure
REQ-029 A shared package SHALL hold: the state enum (SWALLOW, MAIN), the default WIDTH, P_DEF and S_DEF, and the clamp rule constants.
REQ-030 The cycle counter SHALL be one sub-module, down_counter (loadable, WIDTH bits, zero flag); the FSM, shadow register and clamp logic stay in pulse_swallow_ctrl.

Verification
REQ-031 Reset defaults P=8, S=0: mod is always 0; tc is high on every 8th cycle (cycles 7, 15, ...).
REQ-032 Load P=5, S=2 mid-period: the current period is unchanged; the next period shows mod = 1,1,0,0,0 and tc on its 5th cycle; with the real prescaler the output period is 17 input clocks.
REQ-033 Load P=4, S=4: mod is always 1; tc every 4 cycles; the output period is 16 input clocks. Load P=4, S=0: the output period is 12 input clocks.
REQ-034 Load P=3, S=7: S is clamped to 3 and cfg_err = 1 from the next period; load P=0, S=0: tc every cycle, mod = 0, cfg_err = 1.
REQ-035 load on the tc cycle with P=6, S=1: the next period is 6 cycles long with mod high only in its first cycle.
REQ-036 Assert rstb at c = 3 of a P=5 period: outputs reach their reset values immediately (no clock needed); after release the counting restarts at c = 0 with the P_DEF/S_DEF configuration.

Source files
------------

// File: rtl/pulse_swallow_ctrl_pkg.sv
// Shared definitions for the pulse-swallow controller: FSM encoding, default
// configuration and the clamp rule applied to program/swallow values.
package pulse_swallow_ctrl_pkg;

    // mod is taken straight from the state flop, so SWALLOW must encode as 1.
    typedef enum logic {
        ST_MAIN    = 1'b0,
        ST_SWALLOW = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 6;
    localparam int P_DEF_DEF = 8;
    localparam int S_DEF_DEF = 0;

    // A program value of zero is replaced by P_MIN. A swallow value above the
    // program value is clamped to the program value. Either case flags cfg_err.
    localparam int P_MIN = 1;

endpackage

// File: rtl/pulse_swallow_ctrl_down_counter.sv
// Loadable WIDTH-bit down counter with a zero flag. It holds at zero until it
// is reloaded. The asynchronous reset value is set by a parameter.
module down_counter
    import pulse_swallow_ctrl_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rstb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values that were present before the edge.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Pulse-swallow controller for a dual-modulus 3/4 prescaler. One period lasts
// P clk_in cycles, and mod is high for the first S of them (3*P + S input clocks).
module pulse_swallow_ctrl
    import pulse_swallow_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int P_DEF = P_DEF_DEF,
    parameter int S_DEF = S_DEF_DEF
) (
    input  logic             clk_in,
    input  logic             rstb,
    input  logic [WIDTH-1:0] p_val,
    input  logic [WIDTH-1:0] s_val,
    input  logic             load,
    output logic             mod,
    output logic             tc,
    output logic             cfg_err
);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] s;
        logic             err;
    } cfg_t;

    function automatic cfg_t clamp_cfg(input logic [WIDTH-1:0] p,
                                       input logic [WIDTH-1:0] s);
        cfg_t r;
        r.p   = p;
        r.s   = s;
        r.err = 1'b0;
        if (p == '0) begin
            r.p   = WIDTH'(P_MIN);
            r.err = 1'b1;
        end
        if (s > r.p) begin
            r.s   = r.p;
            r.err = 1'b1;
        end
        return r;
    endfunction

    localparam cfg_t             RST_CFG   = clamp_cfg(WIDTH'(P_DEF), WIDTH'(S_DEF));
    localparam state_e           RST_STATE = (RST_CFG.s != '0) ? ST_SWALLOW : ST_MAIN;
    localparam logic [WIDTH-1:0] RST_CNT   = RST_CFG.p - WIDTH'(1);

    cfg_t   shadow_d, shadow_q;
    cfg_t   act_d, act_q;
    state_e state_d, state_q;
    logic   tc_d, tc_q;

    cfg_t             load_cfg;
    cfg_t             next_cfg;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_zero;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] main_len;

    // cnt_q holds the cycles left in the period (P_act-1-c). A zero count marks
    // the tc cycle, and the counter reloads on the edge that ends that cycle.
    down_counter #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_CNT)
    ) u_cnt (
        .clk_in   (clk_in),
        .rstb     (rstb),
        .load     (cnt_zero),
        .load_val (cnt_load_val),
        .count    (cnt_q),
        .zero     (cnt_zero)
    );

    // A load on the tc cycle bypasses the shadow so it can govern the next period.
    always_comb begin
        load_cfg     = clamp_cfg(p_val, s_val);
        next_cfg     = load ? load_cfg : shadow_q;
        shadow_d     = load ? load_cfg : shadow_q;
        cnt_load_val = next_cfg.p - WIDTH'(1);
        rem_next     = cnt_q - WIDTH'(1);
        main_len     = act_q.p - act_q.s;
    end

    // c_next < S is equivalent to rem_next >= P - S, so mod comes from the counter.
    always_comb begin
        act_d   = act_q;
        state_d = state_q;
        tc_d    = tc_q;
        if (cnt_zero) begin
            act_d   = next_cfg;
            state_d = (next_cfg.s != '0) ? ST_SWALLOW : ST_MAIN;
            tc_d    = (next_cfg.p == WIDTH'(1));
        end else begin
            state_d = (rem_next >= main_len) ? ST_SWALLOW : ST_MAIN;
            tc_d    = (cnt_q == WIDTH'(1));
        end
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            shadow_q <= RST_CFG;
            act_q    <= RST_CFG;
            state_q  <= RST_STATE;
            tc_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
        end
    end

    assign mod     = (state_q == ST_SWALLOW);
    assign tc      = tc_q;
    assign cfg_err = act_q.err;

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Scoreboard bench for pulse_swallow_ctrl: the stimulus queues per-cycle
// expected {mod,tc,cfg_err}, and a monitor pops and compares them on every falling edge.
`timescale 1ns/1ps
module tb_pulse_swallow_ctrl;

    typedef struct packed {
        logic mod;
        logic tc;
        logic err;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rstb;
    logic [5:0] p_val;
    logic [5:0] s_val;
    logic       load;
    logic       mod;
    logic       tc;
    logic       cfg_err;

    exp_t exp_q[$];
    int   meas[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   len     = 0;
    bit   mon_en  = 1'b0;

    pulse_swallow_ctrl dut (
        .clk_in  (clk_in),
        .rstb    (rstb),
        .p_val   (p_val),
        .s_val   (s_val),
        .load    (load),
        .mod     (mod),
        .tc      (tc),
        .cfg_err (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Queue cycles c0..c1-1 of a period of p cycles with swallow count s.
    task automatic push_period(input int p, input int s, input logic err,
                               input int c0, input int c1);
        exp_t e;
        for (int c = c0; c < c1; c++) begin
            e.mod = (c < s);
            e.tc  = (c == p - 1);
            e.err = err;
            exp_q.push_back(e);
        end
    endtask

    task automatic goto(input int j);
        while (cyc < j) begin
            @(posedge clk_in);
            cyc++;
        end
        #2;
    endtask

    task automatic ld(input int j, input int p, input int s);
        goto(j);
        p_val = 6'(p);
        s_val = 6'(s);
        load  = 1'b1;
        goto(j + 1);
        load  = 1'b0;
    endtask

    // The monitor also measures each period's length in prescaler input clocks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("cycle_mod_tc_err", {29'd0, mod, tc, cfg_err}, {29'd0, e});
                end
                len += mod ? 4 : 3;
                if (tc) begin
                    meas.push_back(len);
                    len = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb  = 1'b0;
        load  = 1'b0;
        p_val = '0;
        s_val = '0;
        #3;
        check("reset_mod", {31'd0, mod}, 32'd0);
        check("reset_tc", {31'd0, tc}, 32'd0);
        check("reset_cfg_err", {31'd0, cfg_err}, 32'd0);

        // Expected output for periods 1..15 (period 15 is cut off by reset at c=3).
        push_period(8, 0, 1'b0, 1, 8);
        push_period(8, 0, 1'b0, 0, 8);
        push_period(8, 0, 1'b0, 0, 8);
        push_period(5, 2, 1'b0, 0, 5);
        push_period(5, 2, 1'b0, 0, 5);
        push_period(4, 4, 1'b0, 0, 4);
        push_period(4, 4, 1'b0, 0, 4);
        push_period(3, 3, 1'b1, 0, 3);
        push_period(6, 1, 1'b0, 0, 6);
        push_period(1, 0, 1'b1, 0, 1);
        push_period(1, 0, 1'b1, 0, 1);
        push_period(1, 0, 1'b1, 0, 1);
        push_period(4, 0, 1'b0, 0, 4);
        push_period(5, 2, 1'b0, 0, 5);
        push_period(5, 2, 1'b0, 0, 3);

        @(negedge clk_in);
        #1;
        rstb = 1'b1;
        cyc  = 0;
        check("c0_mod", {31'd0, mod}, 32'd0);
        check("c0_tc", {31'd0, tc}, 32'd0);
        mon_en = 1'b1;

        ld(18, 3, 1);   // superseded by the next load in the same period
        ld(20, 5, 2);
        ld(30, 4, 4);
        ld(39, 3, 7);
        ld(44, 6, 1);   // coincides with the tc cycle
        ld(46, 0, 0);
        ld(53, 4, 0);   // coincides with the tc cycle (P=1)
        ld(55, 5, 2);

        goto(66);
        mon_en = 1'b0;
        check("queue_empty_before_reset", exp_q.size(), 32'd0);
        rstb = 1'b0;
        #1;
        check("async_reset_mod", {31'd0, mod}, 32'd0);
        check("async_reset_tc", {31'd0, tc}, 32'd0);
        check("async_reset_cfg_err", {31'd0, cfg_err}, 32'd0);
        repeat (3) begin
            @(negedge clk_in);
            check("no_tc_during_reset", {31'd0, tc}, 32'd0);
        end

        @(negedge clk_in);
        #1;
        rstb = 1'b1;
        cyc  = 0;
        len  = 0;
        check("restart_c0_mod", {31'd0, mod}, 32'd0);
        check("restart_c0_tc", {31'd0, tc}, 32'd0);
        push_period(8, 0, 1'b0, 1, 8);
        push_period(8, 0, 1'b0, 0, 8);
        mon_en = 1'b1;

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk_in);
        end
        mon_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        if (meas.size() > 12) begin
            check("div_len_p5_s2", meas[3], 32'd17);
            check("div_len_p4_s4", meas[5], 32'd16);
            check("div_len_p4_s0", meas[12], 32'd12);
        end else begin
            check("period_count", meas.size(), 32'd13);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
